serial_request_deserializer: RTL and testbench
==============================================

Name: serial_request_deserializer

Overview:
- Receive side of the 2-lane CPU serial request link, directly downstream of the input pads inside top_level.
- Shifts 2 bits per beat from cpu_serial_request_0/1, qualified by cpu_serial_request_ready_0/1, into a full request word.
- Presents the word to the cache core through a one-entry valid/ready output register.
- Detects lane-valid mismatch, inter-beat timeout and overflow. The serial source has no backpressure.

Parameters:
- WORD_WIDTH, 48, request word width in bits; must be even and at least 4. BEATS = WORD_WIDTH/2.
- TIMEOUT, 16, number of consecutive idle cycles allowed inside a partial word before it is discarded; 0 disables the timeout.

Ports:
- clock  input  1  single clock, rising edge.
- reset  input  1  asynchronous, active-low reset.
- serial_data  input  2  [1] = cpu_serial_request_1, [0] = cpu_serial_request_0.
- serial_valid  input  2  [1] = cpu_serial_request_ready_1, [0] = cpu_serial_request_ready_0.
- word_out  output  WORD_WIDTH  assembled request word.
- word_valid  output  1  word_out holds an unconsumed word.
- word_ready  input  1  consumer accepts word_out this cycle.
- overflow  output  1  sticky: a completed word was dropped.
- frame_error  output  1  sticky: lane mismatch or timeout.
- clear_errors  input  1  synchronous clear of both sticky flags.

Behaviour:
- Reset (reset=0, asynchronous, any state):
  - word_out=0, word_valid=0, overflow=0, frame_error=0.
  - Shift register=0, beat count=0, idle count=0, state=IDLE.
  - A partial word in flight is lost.
- Beat definition: serial_valid==2'b11.
  - shift <= {shift[WORD_WIDTH-3:0], serial_data[1], serial_data[0]}.
  - Bit order is MSB-first: the first beat carries bits [W-1:W-2], with lane 1 as the higher bit.
- States: IDLE (count=0) and RECV (0<count<BEATS).
  - IDLE + beat -> RECV, count=1.
  - RECV + beat with count<BEATS-1 -> count+1.
  - Final beat (count==BEATS-1) -> IDLE, count=0, word complete.
  - When BEATS==1 is impossible (WORD_WIDTH>=4), no special case is needed.
- Completion:
  - Assembled word = {shift[W-3:0], serial_data}.
  - If word_valid==0 or (word_valid && word_ready) in the final-beat cycle, load word_out and set word_valid=1 on that same edge. Latency: word_valid is high in the cycle after the final beat is sampled.
  - Otherwise the new word is dropped, overflow is set, and the held word_out/word_valid are unchanged.
- Output handshake:
  - word_valid && word_ready clears word_valid unless a new word loads on the same edge; a new load keeps word_valid=1 with the new data.
  - word_out stays stable while word_valid && !word_ready.
  - word_ready is ignored while word_valid=0.
- Lane mismatch (serial_valid==2'b01 or 2'b10) in any state:
  - Set frame_error, discard the partial word, go to IDLE with count=0.
  - No data is shifted.
- Timeout (TIMEOUT>0):
  - In RECV, the idle counter increments on each serial_valid==2'b00 cycle and clears on every beat.
  - When it reaches TIMEOUT: discard the partial word, set frame_error, go to IDLE.
  - The idle counter is held at 0 in IDLE.
- Sticky flags:
  - clear_errors=1 clears overflow and frame_error on the next edge.
  - A set event in the same cycle wins over clear.
- The output register is independent of receive errors: a held word survives mismatch and timeout.

Test Plan (WORD_WIDTH=8, TIMEOUT=4):
- Basic word: beats serial_data=10,10,01,01 with valid=11, word_ready=1 -> word_out=0xA5 and word_valid=1 one cycle after the 4th beat, cleared the next cycle; flags stay 0.
- Backpressure/overflow:
  - Send 0xA5, hold word_ready=0, send 0x3C -> word_out stays 0xA5 and overflow=1.
  - Then word_ready=1 -> word_valid=0.
  - clear_errors=1 -> overflow=0.
- Back-to-back with same-edge accept:
  - Send 0x12 then 0x34 with no gap; word_ready=1 exactly in the cycle of the second word's final beat -> word_out changes 0x12 to 0x34 with word_valid never dropping; overflow=0.
- Lane mismatch:
  - After 2 beats (11,11), apply serial_valid=01 -> frame_error=1.
  - Then 4 beats 00,00,11,11 -> word_out=0x0F (clean resync).
- Timeout:
  - 1 beat, then 4 idle cycles -> frame_error=1, partial word discarded.
  - Next 4 beats 01,01,01,01 -> word_out=0x55.
  - Repeat with 3 idle cycles -> no error, and the word completes with the earlier beats retained.
- Async reset mid-word: assert reset=0 between beats 2 and 3 (off clock edge) -> all outputs 0 immediately; after release, a full 4-beat word 0xC3 is received correctly.

Source files
------------

// File: rtl/serial_request_deserializer.sv
// Receive side of the 2-lane serial request link: assembles 2-bit beats into a request word and
// hands it to the cache core through a one-entry valid/ready register, flagging link errors.
module serial_request_deserializer #(
  parameter int unsigned WORD_WIDTH = 48,
  parameter int unsigned TIMEOUT    = 16
) (
  input  logic                  clock,
  input  logic                  reset,
  input  logic [1:0]            serial_data,
  input  logic [1:0]            serial_valid,
  output logic [WORD_WIDTH-1:0] word_out,
  output logic                  word_valid,
  input  logic                  word_ready,
  output logic                  overflow,
  output logic                  frame_error,
  input  logic                  clear_errors
);

  localparam int unsigned Beats = WORD_WIDTH / 2;
  localparam int unsigned CntW  = $clog2(Beats);
  localparam int unsigned IdleW = (TIMEOUT > 0) ? $clog2(TIMEOUT + 1) : 1;

  localparam logic [CntW-1:0]  LastBeat  = CntW'(Beats - 1);
  localparam logic [IdleW-1:0] IdleLimit = IdleW'(TIMEOUT - 1);

  typedef enum logic [0:0] {StIdle, StRecv} state_e;

  state_e                  state_q, state_d;
  logic [CntW-1:0]         count_q, count_d;
  logic [IdleW-1:0]        idle_q, idle_d;
  logic [WORD_WIDTH-1:0]   shift_q, shift_d;
  logic [WORD_WIDTH-1:0]   word_q, word_d;
  logic                    valid_q, valid_d;
  logic                    overflow_q, overflow_d;
  logic                    frame_error_q, frame_error_d;

  logic beat, mismatch;

  assign beat     = (serial_valid == 2'b11);
  assign mismatch = serial_valid[1] ^ serial_valid[0];

  always_comb begin
    state_d       = state_q;
    count_d       = count_q;
    idle_d        = idle_q;
    shift_d       = shift_q;
    word_d        = word_q;
    valid_d       = valid_q & ~word_ready;
    // Clear first so a set event in the same cycle takes priority.
    overflow_d    = overflow_q & ~clear_errors;
    frame_error_d = frame_error_q & ~clear_errors;

    if (beat) begin
      shift_d = {shift_q[WORD_WIDTH-3:0], serial_data};
      idle_d  = '0;
      if (state_q == StRecv && count_q == LastBeat) begin
        state_d = StIdle;
        count_d = '0;
        if (!valid_q || word_ready) begin
          word_d  = {shift_q[WORD_WIDTH-3:0], serial_data};
          valid_d = 1'b1;
        end else begin
          overflow_d = 1'b1;
        end
      end else begin
        state_d = StRecv;
        count_d = count_q + CntW'(1);
      end
    end else if (mismatch) begin
      state_d       = StIdle;
      count_d       = '0;
      idle_d        = '0;
      shift_d       = '0;
      frame_error_d = 1'b1;
    end else if (state_q == StRecv && TIMEOUT > 0) begin
      if (idle_q == IdleLimit) begin
        state_d       = StIdle;
        count_d       = '0;
        idle_d        = '0;
        shift_d       = '0;
        frame_error_d = 1'b1;
      end else begin
        idle_d = idle_q + IdleW'(1);
      end
    end
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      state_q       <= StIdle;
      count_q       <= '0;
      idle_q        <= '0;
      shift_q       <= '0;
      word_q        <= '0;
      valid_q       <= 1'b0;
      overflow_q    <= 1'b0;
      frame_error_q <= 1'b0;
    end else begin
      state_q       <= state_d;
      count_q       <= count_d;
      idle_q        <= idle_d;
      shift_q       <= shift_d;
      word_q        <= word_d;
      valid_q       <= valid_d;
      overflow_q    <= overflow_d;
      frame_error_q <= frame_error_d;
    end
  end

  assign word_out    = word_q;
  assign word_valid  = valid_q;
  assign overflow    = overflow_q;
  assign frame_error = frame_error_q;

endmodule

// File: tb/tb_serial_request_deserializer.sv
// Bench for serial_request_deserializer: a vector table, directed multi-cycle sequences and a
// randomized run checked against a beat-queue reference model.
module tb_serial_request_deserializer;

  localparam int unsigned W     = 8;
  localparam int unsigned TO    = 4;
  localparam int unsigned BEATS = W / 2;

  logic         clock = 1'b0;
  logic         reset = 1'b0;
  logic [1:0]   serial_data = 2'b00;
  logic [1:0]   serial_valid = 2'b00;
  logic [W-1:0] word_out;
  logic         word_valid;
  logic         word_ready = 1'b0;
  logic         overflow;
  logic         frame_error;
  logic         clear_errors = 1'b0;

  serial_request_deserializer #(.WORD_WIDTH(W), .TIMEOUT(TO)) dut (
    .clock        (clock),
    .reset        (reset),
    .serial_data  (serial_data),
    .serial_valid (serial_valid),
    .word_out     (word_out),
    .word_valid   (word_valid),
    .word_ready   (word_ready),
    .overflow     (overflow),
    .frame_error  (frame_error),
    .clear_errors (clear_errors)
  );

  always #5 clock = ~clock;

  int checks   = 0;
  int failures = 0;

  // Reference model: partial word kept as a queue of beats, errors judged from its length.
  int           m_beats[$];
  int           m_idle;
  logic [W-1:0] m_word;
  logic         m_valid, m_ovf, m_fe;

  function automatic void model_reset();
    m_beats.delete();
    m_idle  = 0;
    m_word  = '0;
    m_valid = 1'b0;
    m_ovf   = 1'b0;
    m_fe    = 1'b0;
  endfunction

  function automatic void model_step(input logic [1:0] v, input logic [1:0] d,
                                     input logic rdy, input logic clr);
    logic         load = 1'b0;
    logic         ovf_set = 1'b0;
    logic         fe_set = 1'b0;
    logic [W-1:0] w = '0;
    if (v == 2'b11) begin
      m_beats.push_back(int'(d));
      m_idle = 0;
      if (m_beats.size() == BEATS) begin
        foreach (m_beats[i]) w = (w << 2) | W'(m_beats[i]);
        m_beats.delete();
        if (!m_valid || rdy) load = 1'b1;
        else ovf_set = 1'b1;
      end
    end else if (v == 2'b01 || v == 2'b10) begin
      m_beats.delete();
      m_idle = 0;
      fe_set = 1'b1;
    end else if (m_beats.size() > 0) begin
      m_idle++;
      if (m_idle == TO) begin
        m_beats.delete();
        m_idle = 0;
        fe_set = 1'b1;
      end
    end
    if (load) begin
      m_word  = w;
      m_valid = 1'b1;
    end else if (m_valid && rdy) begin
      m_valid = 1'b0;
    end
    m_ovf = (m_ovf && !clr) || ovf_set;
    m_fe  = (m_fe && !clr) || fe_set;
  endfunction

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got=%0h want=%0h at %0t", name, act, exp, $time);
    end
  endtask

  // Drive one cycle on the falling edge, then settle just after the rising edge.
  task automatic step(input logic [1:0] v, input logic [1:0] d, input logic rdy,
                      input logic clr);
    @(negedge clock);
    serial_valid = v;
    serial_data  = d;
    word_ready   = rdy;
    clear_errors = clr;
    @(posedge clock);
    #1;
    model_step(v, d, rdy, clr);
  endtask

  task automatic send_word(input logic [W-1:0] w, input logic rdy);
    for (int i = BEATS - 1; i >= 0; i--) step(2'b11, w[2*i +: 2], rdy, 1'b0);
  endtask

  task automatic check_outputs(input string tag, input logic [W-1:0] w, input logic v,
                               input logic o, input logic f);
    check({tag, ".word_out"}, 32'(word_out), 32'(w));
    check({tag, ".word_valid"}, 32'(word_valid), 32'(v));
    check({tag, ".overflow"}, 32'(overflow), 32'(o));
    check({tag, ".frame_error"}, 32'(frame_error), 32'(f));
  endtask

  typedef struct {
    logic [1:0]   v;
    logic [1:0]   d;
    logic         rdy;
    logic         clr;
    logic [W-1:0] w;
    logic         wv;
    logic         ovf;
    logic         fe;
  } vec_t;

  vec_t vecs[$];

  function automatic void add(input logic [1:0] v, input logic [1:0] d, input logic rdy,
                              input logic clr, input logic [W-1:0] w, input logic wv,
                              input logic ovf, input logic fe);
    vec_t e;
    e.v = v; e.d = d; e.rdy = rdy; e.clr = clr; e.w = w; e.wv = wv; e.ovf = ovf; e.fe = fe;
    vecs.push_back(e);
  endfunction

  initial begin
    // Basic word 0xA5 with ready held high.
    add(2'b11, 2'b10, 1, 0, 8'h00, 0, 0, 0);
    add(2'b11, 2'b10, 1, 0, 8'h00, 0, 0, 0);
    add(2'b11, 2'b01, 1, 0, 8'h00, 0, 0, 0);
    add(2'b11, 2'b01, 1, 0, 8'hA5, 1, 0, 0);
    add(2'b00, 2'b00, 1, 0, 8'hA5, 0, 0, 0);
    // Backpressure: 0xA5 held, 0x3C dropped.
    add(2'b11, 2'b10, 0, 0, 8'hA5, 0, 0, 0);
    add(2'b11, 2'b10, 0, 0, 8'hA5, 0, 0, 0);
    add(2'b11, 2'b01, 0, 0, 8'hA5, 0, 0, 0);
    add(2'b11, 2'b01, 0, 0, 8'hA5, 1, 0, 0);
    add(2'b11, 2'b00, 0, 0, 8'hA5, 1, 0, 0);
    add(2'b11, 2'b11, 0, 0, 8'hA5, 1, 0, 0);
    add(2'b11, 2'b11, 0, 0, 8'hA5, 1, 0, 0);
    add(2'b11, 2'b00, 0, 0, 8'hA5, 1, 1, 0);
    add(2'b00, 2'b00, 1, 0, 8'hA5, 0, 1, 0);
    add(2'b00, 2'b00, 0, 1, 8'hA5, 0, 0, 0);
    // Back-to-back 0x12 then 0x34, accepted on the final beat of 0x34.
    add(2'b11, 2'b00, 0, 0, 8'hA5, 0, 0, 0);
    add(2'b11, 2'b01, 0, 0, 8'hA5, 0, 0, 0);
    add(2'b11, 2'b00, 0, 0, 8'hA5, 0, 0, 0);
    add(2'b11, 2'b10, 0, 0, 8'h12, 1, 0, 0);
    add(2'b11, 2'b00, 0, 0, 8'h12, 1, 0, 0);
    add(2'b11, 2'b11, 0, 0, 8'h12, 1, 0, 0);
    add(2'b11, 2'b01, 0, 0, 8'h12, 1, 0, 0);
    add(2'b11, 2'b00, 1, 0, 8'h34, 1, 0, 0);
    add(2'b00, 2'b00, 1, 0, 8'h34, 0, 0, 0);

    model_reset();
    repeat (3) @(posedge clock);
    #1;
    check_outputs("reset", 8'h00, 0, 0, 0);
    @(negedge clock);
    reset = 1'b1;

    for (int i = 0; i < vecs.size(); i++) begin
      step(vecs[i].v, vecs[i].d, vecs[i].rdy, vecs[i].clr);
      check_outputs($sformatf("vec%0d", i), vecs[i].w, vecs[i].wv, vecs[i].ovf, vecs[i].fe);
    end

    // Lane mismatch mid-word, then clean resync to 0x0F.
    step(2'b11, 2'b11, 1, 0);
    step(2'b11, 2'b11, 1, 0);
    step(2'b01, 2'b11, 1, 0);
    check("mismatch.frame_error", 32'(frame_error), 32'd1);
    send_word(8'h0F, 1);
    check_outputs("resync", 8'h0F, 1, 0, 1);

    // Timeout after four idle cycles discards the partial word.
    step(2'b00, 2'b00, 1, 1);
    check("clr.frame_error", 32'(frame_error), 32'd0);
    step(2'b11, 2'b10, 1, 0);
    repeat (3) step(2'b00, 2'b00, 1, 0);
    check("idle3.frame_error", 32'(frame_error), 32'd0);
    step(2'b00, 2'b00, 1, 0);
    check("timeout.frame_error", 32'(frame_error), 32'd1);
    send_word(8'h55, 1);
    check_outputs("after_timeout", 8'h55, 1, 0, 1);

    // Three idle cycles is tolerated; earlier beat retained. Word held with ready low.
    step(2'b00, 2'b00, 1, 1);
    step(2'b11, 2'b11, 0, 0);
    repeat (3) step(2'b00, 2'b00, 0, 0);
    repeat (3) step(2'b11, 2'b01, 0, 0);
    check_outputs("no_timeout", 8'hD5, 1, 0, 0);

    // Asynchronous reset between beats 2 and 3 of 0xC3.
    step(2'b11, 2'b11, 0, 0);
    step(2'b11, 2'b00, 0, 0);
    #1;
    reset = 1'b0;
    #1;
    check_outputs("async_reset", 8'h00, 0, 0, 0);
    model_reset();
    #1;
    reset = 1'b1;
    send_word(8'hC3, 0);
    check_outputs("after_reset", 8'hC3, 1, 0, 0);

    // Randomized traffic against the reference model.
    for (int n = 0; n < 1500; n++) begin
      int unsigned r = $urandom_range(0, 99);
      logic [1:0] v;
      if (r < 70) v = 2'b11;
      else if (r < 95) v = 2'b00;
      else if (r < 97) v = 2'b01;
      else v = 2'b10;
      step(v, 2'($urandom), ($urandom_range(0, 99) < 40), ($urandom_range(0, 99) < 5));
      check("rand.word_valid", 32'(word_valid), 32'(m_valid));
      check("rand.word_out", 32'(word_out), 32'(m_word));
      check("rand.overflow", 32'(overflow), 32'(m_ovf));
      check("rand.frame_error", 32'(frame_error), 32'(m_fe));
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
